discharge_scheduler: RTL and testbench
======================================

DISCHARGE_SCHEDULER -- requirements
Module: discharge_scheduler

Interface
REQ-001 The module SHALL have parameter T_WAIT_MAX, default 16'd250: breakdown-wait timeout, clk cycles (5 us at 50 MHz).
REQ-002 The module SHALL have parameter I_START, default 16'd3060: current threshold that marks breakdown.
REQ-003 The module SHALL have port clk, input, 1 bit: single system clock, 50 MHz.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: global machining enable, level.
REQ-006 The module SHALL have port ch_en, input, 4 bits: per-power-channel enable (Start1..Start4 equivalents).
REQ-007 The module SHALL have port ton, input, 16 bits: on-time after breakdown, cycles.
REQ-008 The module SHALL have port ts, input, 16 bits: pulse period, cycles.
REQ-009 The module SHALL have port i_sample, input, 16 bits: filtered gap current, unsigned.
REQ-010 The module SHALL have port short_flag, input, 1 bit: short-circuit indication from pulse sort.
REQ-011 The module SHALL have port pwm, output, 4 bits: one-hot gate drive of the active channel.
REQ-012 The module SHALL have port pwm_cut, output, 1 bit: one-cycle cut-off strobe.
REQ-013 The module SHALL have port cur_ch, output, 2 bits: index of the channel owning the current pulse.
REQ-014 The module SHALL have port pulse_done, output, 1 bit: one-cycle strobe at pulse end.
REQ-015 The module SHALL have port open_pulse, output, 1 bit: one-cycle strobe when a breakdown timeout occurs.
REQ-016 The module SHALL have port busy, output, 1 bit: high in any state except IDLE.

Function
REQ-017 The module SHALL implement states IDLE, SELECT, WAIT_BD, ON and OFF.
REQ-018 In IDLE, the module SHALL go to SELECT on the cycle after start=1 and ch_en!=0.
REQ-019 In SELECT (one cycle), the module SHALL grant the next enabled channel in round-robin order, starting after the last granted channel and wrapping from 3 to 0. After reset the search SHALL start at channel 0.
REQ-020 In SELECT, the module SHALL latch ton and ts into internal registers. Input changes during a pulse SHALL have no effect until the next SELECT.
REQ-021 In SELECT, the module SHALL compute toff = ts - ton, using 16-bit arithmetic. If ts <= ton, toff SHALL be forced to 1.
REQ-022 In WAIT_BD, pwm[cur_ch] SHALL be 1 and a wait counter SHALL increment each cycle.
REQ-023 In WAIT_BD, if i_sample >= I_START, the module SHALL go to ON and clear the counter.
REQ-024 In WAIT_BD, if the counter reaches T_WAIT_MAX-1 without breakdown, the module SHALL pulse open_pulse and go to OFF.
REQ-025 In ON, pwm[cur_ch] SHALL be 1 for exactly the latched ton cycles, then the module SHALL go to OFF. A latched ton of 0 SHALL be treated as 1.
REQ-026 A short_flag=1 in ON SHALL drop pwm to 0 on the next cycle, pulse pwm_cut for one cycle, and go to OFF. short_flag SHALL be ignored in the other states.
REQ-027 In OFF, pwm SHALL be 0 for the latched toff cycles. On leaving OFF, the module SHALL pulse pulse_done and go to SELECT, or to IDLE if start=0 or ch_en=0.
REQ-028 If start=0 in WAIT_BD or ON, the module SHALL force pwm to 0 next cycle and go to OFF, so the off-time is always completed.
REQ-029 If ch_en[cur_ch] is deasserted mid-pulse, the module SHALL finish the current pulse. The channel SHALL be skipped at the next SELECT.
REQ-030 pwm SHALL be registered, one-hot or zero, and never have more than one bit set.
REQ-031 At most one of pwm_cut, pulse_done and open_pulse SHALL be high in any cycle, except that pulse_done may coincide with none of them.

Reset
REQ-032 When rst=1 at a clk edge, the state SHALL become IDLE, and pwm, pwm_cut, pulse_done, open_pulse and busy SHALL be 0.
REQ-033 When rst=1 at a clk edge, cur_ch SHALL be 2'd3 so that the first grant is channel 0, and all counters and latched values SHALL be 0.
REQ-034 A reset asserted mid-pulse SHALL drive pwm to 0 on the same edge, with no pwm_cut strobe.

Verification
REQ-035 Scenario, normal pulse: ch_en=4'b0001, ton=100, ts=300, and i_sample>=3060 on the 10th WAIT_BD cycle. Required: pwm[0] high for 10+100 cycles, low for 200 cycles, pulse_done once, repeating.
REQ-036 Scenario, round-robin: ch_en=4'b1011. Required: grant order 0,1,3,0,1,3. After ch_en becomes 4'b0100 mid-pulse, the current pulse finishes, then only channel 2 is granted.
REQ-037 Scenario, open gap: i_sample held at 0. Required: pwm high for 250 cycles, open_pulse once, then OFF for ts-ton cycles.
REQ-038 Scenario, short: short_flag=1 on ON cycle 20. Required: pwm drops next cycle, one pwm_cut strobe, full toff honoured.
REQ-039 Scenario, boundary: ton=500, ts=400. Required: toff is 1 cycle. Also ton=0 gives a 1-cycle ON.
REQ-040 Scenario, abort: start=0 in ON. Required: pwm=0 next cycle, OFF completes, then IDLE with busy=0. Reset asserted in WAIT_BD gives pwm=0 immediately and the next grant is channel 0.

Source files
------------

// File: rtl/discharge_scheduler.sv
// Discharge pulse scheduler: hands out breakdown-gated discharge pulses to up
// to four power channels in round-robin order.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | machining disabled or no channel enabled, gates off
//   SELECT   | pick next enabled channel, latch ton/ts for this pulse
//   WAIT_BD  | gate on, waiting for gap current to show breakdown
//   ON       | gate on for the latched on-time after breakdown
//   OFF      | gate off for the latched off-time (ts - ton, minimum 1)
//
// Once a pulse has started, its off-time always completes. A start drop or a
// short only shortens the gate-on part. The only way to cut a pulse short is
// rst.
module discharge_scheduler #(
    parameter logic [15:0] T_WAIT_MAX = 16'd250,
    parameter logic [15:0] I_START    = 16'd3060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  ch_en,
    input  logic [15:0] ton,
    input  logic [15:0] ts,
    input  logic [15:0] i_sample,
    input  logic        short_flag,
    output logic [3:0]  pwm,
    output logic        pwm_cut,
    output logic [1:0]  cur_ch,
    output logic        pulse_done,
    output logic        open_pulse,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT_BD,
        S_ON,
        S_OFF
    } state_t;

    localparam logic [15:0] WAIT_LAST = T_WAIT_MAX - 16'd1;

    state_t      state;
    logic [15:0] ton_q;
    logic [15:0] ts_q;
    logic [15:0] wait_cnt;
    logic [15:0] tmr;

    logic        run_ok;
    logic        pick_vld;
    logic [1:0]  pick_ch;
    logic [15:0] ton_eff;
    logic [15:0] toff_eff;

    // Search order starts one past the last grant. Offset 4 wraps back to the
    // last grant itself, so a lone enabled channel is granted again.
    function automatic logic [2:0] rr_pick(input logic [1:0] last,
                                           input logic [3:0] en);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + i[1:0];
            if (en[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Round-robin grant, continue/stop decision and effective pulse timing
    always_comb begin
        {pick_vld, pick_ch} = rr_pick(cur_ch, ch_en);
        run_ok   = start && (ch_en != 4'b0000);
        ton_eff  = (ton_q == 16'd0) ? 16'd1 : ton_q;
        toff_eff = (ts_q <= ton_q) ? 16'd1 : (ts_q - ton_q);
    end

    // Sequencing FSM. All outputs are registered here. Strobes default low
    // every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_ch     <= 2'd3;
            pwm        <= 4'b0000;
            pwm_cut    <= 1'b0;
            pulse_done <= 1'b0;
            open_pulse <= 1'b0;
            busy       <= 1'b0;
            ton_q      <= 16'd0;
            ts_q       <= 16'd0;
            wait_cnt   <= 16'd0;
            tmr        <= 16'd0;
        end else begin
            pwm_cut    <= 1'b0;
            pulse_done <= 1'b0;
            open_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    pwm <= 4'b0000;
                    if (run_ok) begin
                        state <= S_SELECT;
                        busy  <= 1'b1;
                    end
                end

                S_SELECT: begin
                    if (start && pick_vld) begin
                        cur_ch   <= pick_ch;
                        ton_q    <= ton;
                        ts_q     <= ts;
                        wait_cnt <= 16'd0;
                        pwm      <= 4'b0001 << pick_ch;
                        state    <= S_WAIT_BD;
                    end else begin
                        // Enables vanished between OFF exit and the grant
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                S_WAIT_BD: begin
                    if (!start) begin
                        pwm      <= 4'b0000;
                        wait_cnt <= 16'd0;
                        tmr      <= toff_eff - 16'd1;
                        state    <= S_OFF;
                    end else if (i_sample >= I_START) begin
                        wait_cnt <= 16'd0;
                        tmr      <= ton_eff - 16'd1;
                        state    <= S_ON;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Gap never broke down: give up on this pulse
                        open_pulse <= 1'b1;
                        pwm        <= 4'b0000;
                        wait_cnt   <= 16'd0;
                        tmr        <= toff_eff - 16'd1;
                        state      <= S_OFF;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                S_ON: begin
                    if (!start) begin
                        pwm   <= 4'b0000;
                        tmr   <= toff_eff - 16'd1;
                        state <= S_OFF;
                    end else if (short_flag) begin
                        pwm     <= 4'b0000;
                        pwm_cut <= 1'b1;
                        tmr     <= toff_eff - 16'd1;
                        state   <= S_OFF;
                    end else if (tmr == 16'd0) begin
                        pwm   <= 4'b0000;
                        tmr   <= toff_eff - 16'd1;
                        state <= S_OFF;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end

                S_OFF: begin
                    pwm <= 4'b0000;
                    if (tmr == 16'd0) begin
                        pulse_done <= 1'b1;
                        busy       <= run_ok;
                        state      <= run_ok ? S_SELECT : S_IDLE;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end

                default: begin
                    pwm   <= 4'b0000;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_discharge_scheduler.sv
// Bench for discharge_scheduler. A gap model drives i_sample and short_flag
// from the observed gate. A monitor measures each pulse (channel, gate-on
// cycles, gate-off cycles until pulse_done, strobes) and checks it against
// the expected pulses queued by the stimulus.
module tb_discharge_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  ch_en;
    logic [15:0] ton;
    logic [15:0] ts;
    logic [15:0] i_sample;
    logic        short_flag;
    logic [3:0]  pwm;
    logic        pwm_cut;
    logic [1:0]  cur_ch;
    logic        pulse_done;
    logic        open_pulse;
    logic        busy;

    discharge_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ch_en      (ch_en),
        .ton        (ton),
        .ts         (ts),
        .i_sample   (i_sample),
        .short_flag (short_flag),
        .pwm        (pwm),
        .pwm_cut    (pwm_cut),
        .cur_ch     (cur_ch),
        .pulse_done (pulse_done),
        .open_pulse (open_pulse),
        .busy       (busy)
    );

    typedef struct {
        int ch;
        int hi;
        int lo;
        int op;
        int cut;
    } exp_t;

    typedef struct {
        logic [3:0]  en;
        logic [15:0] ton;
        logic [15:0] ts;
        int          bd;
        int          sh;
        int          ch;
        int          hi;
        int          lo;
        int          op;
        int          cut;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[12];

    int total = 0;
    int bad   = 0;
    int cur_bd = 0;
    int cur_sh = 0;

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic int enc(input logic [3:0] p);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) begin
            if (p[i]) r = i;
        end
        return r;
    endfunction

    task automatic push_exp(input int ch, input int hi, input int lo,
                            input int op, input int cut);
        exp_t e;
        e.ch = ch; e.hi = hi; e.lo = lo; e.op = op; e.cut = cut;
        sb_q.push_back(e);
    endtask

    task automatic wait_pd(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pulse_done && n < 5000);
        if (!pulse_done) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: actual=no pulse_done required=pulse_done", nm);
        end
    endtask

    task automatic wait_pwm(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pwm == 4'b0000 && n < 2000);
        if (pwm == 4'b0000) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: actual=pwm idle required=pwm active", nm);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gap model: breakdown current on WAIT_BD cycle cur_bd (exactly at the
    // threshold), just below threshold otherwise; short on ON cycle cur_sh.
    initial begin
        int hi_cnt;
        hi_cnt     = 0;
        i_sample   = 16'd0;
        short_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (pwm != 4'b0000) hi_cnt++;
            else hi_cnt = 0;
            if (cur_bd == 0) i_sample = 16'd0;
            else if (hi_cnt == cur_bd) i_sample = 16'd3060;
            else i_sample = 16'd3059;
            short_flag = (cur_bd != 0 && cur_sh != 0 && hi_cnt == cur_bd + cur_sh);
        end
    end

    // Pulse monitor / scoreboard consumer
    initial begin
        int   m_hi, m_lo, m_open, m_cut, m_bad, m_ch, pidx;
        exp_t e;
        m_hi = 0; m_lo = 0; m_open = 0; m_cut = 0; m_bad = 0; m_ch = 0; pidx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_hi = 0; m_lo = 0; m_open = 0; m_cut = 0; m_bad = 0;
            end else begin
                if (int'(pwm_cut) + int'(pulse_done) + int'(open_pulse) > 1) m_bad = 1;
                if (pwm_cut) m_cut++;
                if (open_pulse) m_open++;
                if (pulse_done) begin
                    check($sformatf("p%0d_sb_nonempty", pidx), int'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check($sformatf("p%0d_ch", pidx), m_ch, e.ch);
                        check($sformatf("p%0d_cur_ch", pidx), int'(cur_ch), e.ch);
                        check($sformatf("p%0d_on_cycles", pidx), m_hi, e.hi);
                        check($sformatf("p%0d_off_cycles", pidx), m_lo, e.lo);
                        check($sformatf("p%0d_open_pulse", pidx), m_open, e.op);
                        check($sformatf("p%0d_pwm_cut", pidx), m_cut, e.cut);
                        check($sformatf("p%0d_onehot_excl", pidx), m_bad, 0);
                    end
                    pidx++;
                    m_hi = 0; m_lo = 0; m_open = 0; m_cut = 0; m_bad = 0;
                end else if (pwm != 4'b0000) begin
                    if (m_hi == 0) m_ch = enc(pwm);
                    if (!$onehot(pwm) || m_ch < 0 || pwm[m_ch[1:0]] !== 1'b1 || !busy) m_bad = 1;
                    m_hi++;
                end else if (m_hi != 0) begin
                    m_lo++;
                end
            end
        end
    end

    // Stimulus
    initial begin
        vecs[0]  = '{4'b0001, 16'd100, 16'd300, 10, 0,  0, 110, 200, 0, 0};
        vecs[1]  = '{4'b0001, 16'd100, 16'd300, 10, 0,  0, 110, 200, 0, 0};
        vecs[2]  = '{4'b1011, 16'd20,  16'd50,  3,  0,  1, 23,  30,  0, 0};
        vecs[3]  = '{4'b1011, 16'd20,  16'd50,  3,  0,  3, 23,  30,  0, 0};
        vecs[4]  = '{4'b1011, 16'd20,  16'd50,  3,  0,  0, 23,  30,  0, 0};
        vecs[5]  = '{4'b1011, 16'd20,  16'd50,  3,  0,  1, 23,  30,  0, 0};
        vecs[6]  = '{4'b1011, 16'd20,  16'd50,  3,  0,  3, 23,  30,  0, 0};
        vecs[7]  = '{4'b0001, 16'd40,  16'd100, 0,  0,  0, 250, 60,  1, 0};
        vecs[8]  = '{4'b0010, 16'd100, 16'd300, 5,  20, 1, 25,  200, 0, 1};
        vecs[9]  = '{4'b0100, 16'd500, 16'd400, 2,  0,  2, 502, 1,   0, 0};
        vecs[10] = '{4'b0100, 16'd0,   16'd10,  4,  0,  2, 5,   10,  0, 0};
        vecs[11] = '{4'b1000, 16'd7,   16'd7,   1,  0,  3, 8,   1,   0, 0};

        rst   = 1'b1;
        start = 1'b0;
        ch_en = 4'b0000;
        ton   = 16'd0;
        ts    = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cur_ch", int'(cur_ch), 3);
        check("rst_strobes", int'({pwm_cut, pulse_done, open_pulse}), 0);

        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) wait_pd($sformatf("vec%0d", i - 1));
            ch_en  = vecs[i].en;
            ton    = vecs[i].ton;
            ts     = vecs[i].ts;
            cur_bd = vecs[i].bd;
            cur_sh = vecs[i].sh;
            push_exp(vecs[i].ch, vecs[i].hi, vecs[i].lo, vecs[i].op, vecs[i].cut);
            start = 1'b1;
        end

        // Channel set changes mid-pulse: current pulse on ch0 finishes, then ch2
        wait_pd("vec11");
        ch_en = 4'b1011; ton = 16'd20; ts = 16'd50; cur_bd = 3; cur_sh = 0;
        push_exp(0, 23, 30, 0, 0);
        wait_pwm("rr_change");
        ch_en = 4'b0100;

        // start drops on ON cycle 10: gate off next cycle, full off-time, IDLE
        wait_pd("rr_change");
        ton = 16'd100; ts = 16'd300; cur_bd = 5; cur_sh = 0;
        push_exp(2, 15, 200, 0, 0);
        wait_pwm("abort");
        repeat (14) @(negedge clk);
        start = 1'b0;
        wait_pd("abort");
        check("abort_busy_at_done", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("abort_idle_busy", int'(busy), 0);
        check("abort_idle_pwm", int'(pwm), 0);

        // Reset during WAIT_BD: gate off at once, no cut, next grant is ch0
        ch_en = 4'b1111; ton = 16'd10; ts = 16'd20; cur_bd = 0; cur_sh = 0;
        start = 1'b1;
        wait_pwm("pre_reset");
        check("pre_reset_grant", int'(pwm), 8);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_pwm", int'(pwm), 0);
        check("mid_rst_cut", int'(pwm_cut), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cur_ch", int'(cur_ch), 3);
        ton = 16'd5; ts = 16'd10; cur_bd = 2;
        push_exp(0, 7, 5, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_pd("post_reset");
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("end_busy", int'(busy), 0);
        check("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
